// File: rtl/sddr_pkg.sv
// Purpose: shared types and widths for the sddr_ctrl front end (port arbiter and its peers).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sddr_pkg;

  // Byte address: BANK 3 + ROW 13 + COL 10 + 1.
  localparam int SDDR_ADDR_BITS  = 27;
  // One burst: BURST_LENGTH 8 x DATA_BITS 16.
  localparam int SDDR_BURST_BITS = 128;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_ISSUE    = 2'd1,
    ARB_WAIT_RSP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/sddr_rr_picker.sv
// Purpose: combinational round-robin picker; first set request strictly after last_i, wrapping.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides whether to act on the grant.
// Ports: req_i request vector, last_i last granted index -> grant_o one-hot, idx_o index, any_o.
module sddr_rr_picker #(
  parameter int NUM_PORTS = 4,
  parameter int IDX_BITS  = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [IDX_BITS-1:0]  last_i,
  output logic [NUM_PORTS-1:0] grant_o,
  output logic [IDX_BITS-1:0]  idx_o,
  output logic                 any_o
);

  logic [2*NUM_PORTS-1:0] dbl_req;
  logic [2*NUM_PORTS-1:0] mask;
  logic [2*NUM_PORTS-1:0] masked;

  assign any_o = |req_i;

  // Requests are duplicated side by side. The lower copy is masked to positions
  // above last_i and the upper copy is left open, so a plain lowest-bit-first
  // priority search over the double vector yields the wrapped round-robin order
  // without needing NUM_PORTS to be a power of two.
  always_comb begin
    dbl_req = {req_i, req_i};
    for (int i = 0; i < 2*NUM_PORTS; i++) begin
      mask[i] = (i > int'(last_i));
    end
    masked  = dbl_req & mask;
    idx_o   = '0;
    grant_o = '0;
    for (int i = 2*NUM_PORTS-1; i >= 0; i--) begin
      if (masked[i]) begin
        idx_o = (i >= NUM_PORTS) ? IDX_BITS'(i - NUM_PORTS) : IDX_BITS'(i);
      end
    end
    if (any_o) begin
      grant_o[idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/sddr_port_arbiter.sv
// Purpose: round-robin share of the single sddr_ctrl data command port; one transaction in flight.
// Latency: grant->cmd_valid 1 cycle; controller rsp->rsp_ready_o 1 cycle (registered pulse).
// Backpressure: holds the command until data_cmd_ack_i; other requesters wait with valid held.
// Ports: req_* per-port requests / req_ack_o accept pulse; rsp_* shared response; data_cmd_* and
//        data_rsp_ready_i/data_data_i to the controller; busy_o, owner_o status.
module sddr_port_arbiter
  import sddr_pkg::*;
#(
  parameter int NUM_PORTS      = 4,
  parameter int ADDR_BITS      = SDDR_ADDR_BITS,
  parameter int DATA_WIDTH     = SDDR_BURST_BITS,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                  cpu_clock_i,
  input  logic                                  reset_i,
  input  logic [NUM_PORTS-1:0]                  req_valid_i,
  input  logic [NUM_PORTS-1:0][ADDR_BITS-1:0]   req_address_i,
  input  logic [NUM_PORTS-1:0]                  req_write_i,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  req_data_i,
  output logic [NUM_PORTS-1:0]                  req_ack_o,
  output logic [NUM_PORTS-1:0]                  rsp_ready_o,
  output logic [DATA_WIDTH-1:0]                 rsp_data_o,
  output logic                                  rsp_error_o,
  output logic                                  data_cmd_valid_o,
  output logic [ADDR_BITS-1:0]                  data_cmd_address_o,
  output logic                                  data_cmd_write_o,
  output logic [DATA_WIDTH-1:0]                 data_cmd_data_o,
  input  logic                                  data_cmd_ack_i,
  input  logic                                  data_rsp_ready_i,
  input  logic [DATA_WIDTH-1:0]                 data_data_i,
  output logic                                  busy_o,
  output logic [$clog2(NUM_PORTS)-1:0]          owner_o
);

  localparam int          IDX_BITS   = $clog2(NUM_PORTS);
  localparam bit          WDOG_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] WDOG_LIMIT = WDOG_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'hFFFF_FFFF;

  arb_state_t              state_q, state_d;
  logic [IDX_BITS-1:0]     owner_q, owner_d;
  logic [IDX_BITS-1:0]     last_grant_q, last_grant_d;
  logic [ADDR_BITS-1:0]    cmd_addr_q, cmd_addr_d;
  logic                    cmd_write_q, cmd_write_d;
  logic [DATA_WIDTH-1:0]   cmd_data_q, cmd_data_d;
  logic [31:0]             wdog_q, wdog_d;
  logic [NUM_PORTS-1:0]    rsp_ready_q, rsp_ready_d;
  logic                    rsp_error_q, rsp_error_d;
  logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;

  logic [NUM_PORTS-1:0]    pick_onehot;
  logic [IDX_BITS-1:0]     pick_idx;
  logic                    pick_any;
  logic [NUM_PORTS-1:0]    req_ack;

  sddr_rr_picker #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_BITS  (IDX_BITS)
  ) u_picker (
    .req_i   (req_valid_i),
    .last_i  (last_grant_q),
    .grant_o (pick_onehot),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_write_d  = cmd_write_q;
    cmd_data_d   = cmd_data_q;
    wdog_d       = wdog_q;
    rsp_ready_d  = '0;
    rsp_error_d  = 1'b0;
    rsp_data_d   = rsp_data_q;
    req_ack      = '0;

    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          req_ack     = pick_onehot;
          owner_d     = pick_idx;
          cmd_addr_d  = req_address_i[pick_idx];
          cmd_write_d = req_write_i[pick_idx];
          cmd_data_d  = req_data_i[pick_idx];
          state_d     = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        // Fairness pointer moves only once the controller has taken the command.
        if (data_cmd_ack_i) begin
          last_grant_d = owner_q;
          wdog_d       = '0;
          state_d      = ARB_WAIT_RSP;
        end
      end
      ARB_WAIT_RSP: begin
        if (data_rsp_ready_i) begin
          rsp_data_d           = data_data_i;
          rsp_ready_d[owner_q] = 1'b1;
          state_d              = ARB_IDLE;
        end else if (WDOG_EN && (wdog_q == WDOG_LIMIT)) begin
          // Timeout keeps the previous read data on rsp_data_o.
          rsp_ready_d[owner_q] = 1'b1;
          rsp_error_d          = 1'b1;
          state_d              = ARB_IDLE;
        end else if (wdog_q != 32'hFFFF_FFFF) begin
          wdog_d = wdog_q + 32'd1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge cpu_clock_i) begin
    if (reset_i) begin
      state_q      <= ARB_IDLE;
      owner_q      <= '0;
      last_grant_q <= IDX_BITS'(NUM_PORTS - 1);
      cmd_addr_q   <= '0;
      cmd_write_q  <= 1'b0;
      cmd_data_q   <= '0;
      wdog_q       <= '0;
      rsp_ready_q  <= '0;
      rsp_error_q  <= 1'b0;
      rsp_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_write_q  <= cmd_write_d;
      cmd_data_q   <= cmd_data_d;
      wdog_q       <= wdog_d;
      rsp_ready_q  <= rsp_ready_d;
      rsp_error_q  <= rsp_error_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  // The accept pulse is combinational, so mask it while reset is held.
  assign req_ack_o          = req_ack & {NUM_PORTS{~reset_i}};
  assign rsp_ready_o        = rsp_ready_q;
  assign rsp_error_o        = rsp_error_q;
  assign rsp_data_o         = rsp_data_q;
  assign data_cmd_valid_o   = (state_q == ARB_ISSUE);
  assign data_cmd_address_o = cmd_addr_q;
  assign data_cmd_write_o   = cmd_write_q;
  assign data_cmd_data_o    = cmd_data_q;
  assign busy_o             = (state_q != ARB_IDLE);
  assign owner_o            = owner_q;

endmodule

// File: tb/tb_sddr_port_arbiter.sv
module tb_sddr_port_arbiter;

  localparam int NP  = 4;
  localparam int AW  = 27;
  localparam int DW  = 128;
  localparam int TMO = 16;
  localparam int S_IDLE = 0, S_ISSUE = 1, S_WAIT = 2;

  logic                   cpu_clock_i = 1'b0;
  logic                   reset_i;
  logic [NP-1:0]          req_valid_i;
  logic [NP-1:0][AW-1:0]  req_address_i;
  logic [NP-1:0]          req_write_i;
  logic [NP-1:0][DW-1:0]  req_data_i;
  logic [NP-1:0]          req_ack_o;
  logic [NP-1:0]          rsp_ready_o;
  logic [DW-1:0]          rsp_data_o;
  logic                   rsp_error_o;
  logic                   data_cmd_valid_o;
  logic [AW-1:0]          data_cmd_address_o;
  logic                   data_cmd_write_o;
  logic [DW-1:0]          data_cmd_data_o;
  logic                   data_cmd_ack_i;
  logic                   data_rsp_ready_i;
  logic [DW-1:0]          data_data_i;
  logic                   busy_o;
  logic [1:0]             owner_o;

  sddr_port_arbiter #(
    .NUM_PORTS(NP), .ADDR_BITS(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .cpu_clock_i(cpu_clock_i), .reset_i(reset_i),
    .req_valid_i(req_valid_i), .req_address_i(req_address_i),
    .req_write_i(req_write_i), .req_data_i(req_data_i),
    .req_ack_o(req_ack_o), .rsp_ready_o(rsp_ready_o),
    .rsp_data_o(rsp_data_o), .rsp_error_o(rsp_error_o),
    .data_cmd_valid_o(data_cmd_valid_o), .data_cmd_address_o(data_cmd_address_o),
    .data_cmd_write_o(data_cmd_write_o), .data_cmd_data_o(data_cmd_data_o),
    .data_cmd_ack_i(data_cmd_ack_i), .data_rsp_ready_i(data_rsp_ready_i),
    .data_data_i(data_data_i), .busy_o(busy_o), .owner_o(owner_o)
  );

  always #5 cpu_clock_i = ~cpu_clock_i;

  int n_checks = 0;
  int n_bad    = 0;

  // Requester side
  logic [NP-1:0]  r_valid;
  logic [AW-1:0]  r_addr  [NP];
  logic           r_write [NP];
  logic [DW-1:0]  r_data  [NP];
  int             ack_port = -1;

  // Stimulus knobs
  int refill_pct, spawn_pct, ack_pct, stale_pct, reset_pmil, rsp_cfg;
  bit fixed_data;
  int rsp_cd;
  bit armed;

  // Reference model
  int             m_state, m_last, m_owner, m_waited;
  logic [AW-1:0]  m_addr;
  logic           m_wr;
  logic [DW-1:0]  m_wdata;
  logic [NP-1:0]  m_rdy;
  logic           m_err;
  logic [DW-1:0]  m_rsp_data;
  bit             m_data_known;
  int             m_done [NP];

  // Observations
  int dut_done [NP];
  int grants [$];
  int wait_cnt, valid_cnt, err_cnt;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // First valid port after 'last', wrapping modulo NP.
  function automatic int pick(input logic [NP-1:0] v, input int last);
    for (int k = 1; k <= NP; k++) begin
      if (v[(last + k) % NP]) return (last + k) % NP;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_state = S_IDLE; m_last = NP - 1; m_owner = 0; m_waited = 0;
    m_addr = '0; m_wr = 1'b0; m_wdata = '0;
    m_rdy = '0; m_err = 1'b0; m_rsp_data = '0; m_data_known = 1'b1;
  endtask

  task automatic new_req(input int p);
    r_valid[p] = 1'b1;
    r_addr[p]  = AW'($urandom);
    r_write[p] = 1'($urandom_range(1));
    r_data[p]  = rand128();
  endtask

  task automatic drive();
    if (ack_port >= 0) begin
      if ($urandom_range(99) < refill_pct) new_req(ack_port);
      else r_valid[ack_port] = 1'b0;
      ack_port = -1;
    end
    for (int p = 0; p < NP; p++) begin
      if (!r_valid[p] && ($urandom_range(99) < spawn_pct)) new_req(p);
      req_valid_i[p]   = r_valid[p];
      req_address_i[p] = r_addr[p];
      req_write_i[p]   = r_write[p];
      req_data_i[p]    = r_data[p];
    end
    data_cmd_ack_i = ($urandom_range(99) < ack_pct);
    if (m_state == S_WAIT) begin
      if (!armed) begin
        armed = 1'b1;
        if (rsp_cfg == -2) rsp_cd = ($urandom_range(9) == 0) ? -1 : int'($urandom_range(5));
        else rsp_cd = rsp_cfg;
      end
      data_rsp_ready_i = (rsp_cd == 0);
      if (rsp_cd >= 0) rsp_cd--;
    end else begin
      armed = 1'b0;
      data_rsp_ready_i = ($urandom_range(99) < stale_pct);
    end
    data_data_i = fixed_data ? {16{8'hA5}} : rand128();
    reset_i = ($urandom_range(999) < reset_pmil);
  endtask

  // Check outputs mid-cycle, then advance the model across the coming edge.
  task automatic cycle();
    int p;
    logic [NP-1:0] ea;
    @(negedge cpu_clock_i);
    p  = (!reset_i && m_state == S_IDLE) ? pick(req_valid_i, m_last) : -1;
    ea = '0;
    if (p >= 0) ea[p] = 1'b1;
    check_eq("req_ack", 128'(req_ack_o), 128'(ea));
    check_eq("cmd_valid", 128'(data_cmd_valid_o), 128'(m_state == S_ISSUE));
    check_eq("cmd_addr", 128'(data_cmd_address_o), 128'(m_addr));
    check_eq("cmd_write", 128'(data_cmd_write_o), 128'(m_wr));
    check_eq("cmd_data", data_cmd_data_o, m_wdata);
    check_eq("rsp_ready", 128'(rsp_ready_o), 128'(m_rdy));
    check_eq("rsp_error", 128'(rsp_error_o), 128'(m_err));
    if (m_data_known) check_eq("rsp_data", rsp_data_o, m_rsp_data);
    check_eq("busy", 128'(busy_o), 128'(m_state != S_IDLE));
    check_eq("owner", 128'(owner_o), 128'(m_owner));

    for (int i = 0; i < NP; i++) begin
      if (rsp_ready_o[i]) dut_done[i]++;
      if (req_ack_o[i]) grants.push_back(i);
    end
    if (busy_o && !data_cmd_valid_o) wait_cnt++;
    if (data_cmd_valid_o) valid_cnt++;
    if (rsp_error_o && (rsp_ready_o != '0)) err_cnt++;

    if (reset_i) begin
      model_reset();
    end else begin
      m_rdy = '0;
      m_err = 1'b0;
      case (m_state)
        S_IDLE: if (p >= 0) begin
          m_owner = p; m_addr = req_address_i[p]; m_wr = req_write_i[p];
          m_wdata = req_data_i[p]; m_state = S_ISSUE; ack_port = p;
        end
        S_ISSUE: if (data_cmd_ack_i) begin
          m_state = S_WAIT; m_waited = 0; m_last = m_owner;
        end
        default: begin
          m_waited++;
          if (data_rsp_ready_i) begin
            m_rdy[m_owner] = 1'b1; m_rsp_data = data_data_i; m_data_known = !m_wr;
            m_done[m_owner]++; m_state = S_IDLE;
          end else if (m_waited == TMO) begin
            m_rdy[m_owner] = 1'b1; m_err = 1'b1; m_done[m_owner]++; m_state = S_IDLE;
          end
        end
      endcase
    end
    @(posedge cpu_clock_i);
    #1;
  endtask

  task automatic step();
    drive();
    cycle();
  endtask

  task automatic do_reset();
    ack_port = -1;
    r_valid  = '0;
    repeat (2) begin
      drive();
      reset_i = 1'b1;
      cycle();
    end
    grants.delete();
  endtask

  task automatic quiet_knobs();
    refill_pct = 0; spawn_pct = 0; ack_pct = 100; stale_pct = 0;
    reset_pmil = 0; rsp_cfg = 2; fixed_data = 1'b0;
  endtask

  initial begin
    int base, errs;
    int exp_order [5] = '{0, 1, 2, 3, 0};
    logic [DW-1:0] a5;
    a5 = {16{8'hA5}};
    for (int p = 0; p < NP; p++) begin
      m_done[p] = 0; dut_done[p] = 0;
      r_addr[p] = '0; r_write[p] = 1'b0; r_data[p] = '0;
    end
    r_valid = '0; armed = 1'b0; rsp_cd = -1;
    quiet_knobs();
    req_valid_i = '0; req_address_i = '0; req_write_i = '0; req_data_i = '0;
    data_cmd_ack_i = 1'b0; data_rsp_ready_i = 1'b0; data_data_i = '0;
    reset_i = 1'b1;
    repeat (2) @(posedge cpu_clock_i);
    #1;
    model_reset();

    // Single read from port 0.
    do_reset();
    fixed_data = 1'b1;
    r_valid[0] = 1'b1; r_addr[0] = 27'h1000; r_write[0] = 1'b0; r_data[0] = '0;
    base = dut_done[0];
    repeat (8) step();
    check_eq("t1_done", 128'(dut_done[0] - base), 128'(1));
    check_eq("t1_data", rsp_data_o, a5);
    fixed_data = 1'b0;

    // All ports continuously valid.
    do_reset();
    refill_pct = 100; rsp_cfg = 1;
    for (int p = 0; p < NP; p++) new_req(p);
    repeat (30) step();
    check_eq("t2_grants", 128'(grants.size() >= 5), 128'(1));
    for (int i = 0; i < 5 && i < grants.size(); i++)
      check_eq("t2_order", 128'(grants[i]), 128'(exp_order[i]));
    quiet_knobs();

    // Port 2 write with command ack withheld for 5 cycles.
    do_reset();
    r_valid[2] = 1'b1; r_addr[2] = 27'h2A_5A5A; r_write[2] = 1'b1; r_data[2] = rand128();
    step();
    valid_cnt = 0;
    ack_pct = 0;
    repeat (5) step();
    ack_pct = 100;
    repeat (10) step();
    check_eq("t3_valid_cycles", 128'(valid_cnt), 128'(6));

    // Watchdog timeout, then stale responses in IDLE, then a normal request.
    do_reset();
    rsp_cfg = -1;
    r_valid[1] = 1'b1; r_addr[1] = 27'h0ABC; r_write[1] = 1'b0;
    wait_cnt = 0; err_cnt = 0;
    repeat (25) step();
    check_eq("t4_wait_cycles", 128'(wait_cnt), 128'(TMO));
    check_eq("t4_err_pulses", 128'(err_cnt), 128'(1));
    stale_pct = 100;
    repeat (5) step();
    stale_pct = 0; rsp_cfg = 2;
    base = dut_done[3];
    r_valid[3] = 1'b1; r_addr[3] = 27'h0DEF; r_write[3] = 1'b0;
    repeat (10) step();
    check_eq("t4_next_done", 128'(dut_done[3] - base), 128'(1));
    check_eq("t4_err_after", 128'(err_cnt), 128'(1));

    // Reset while waiting for a response; port 0 must then beat port 3.
    do_reset();
    rsp_cfg = -1;
    r_valid[3] = 1'b1; r_addr[3] = 27'h0333; r_write[3] = 1'b0;
    base = dut_done[3];
    repeat (4) step();
    drive();
    reset_i = 1'b1;
    cycle();
    grants.delete();
    rsp_cfg = 1;
    r_valid[0] = 1'b1; r_addr[0] = 27'h0100; r_write[0] = 1'b0;
    r_valid[3] = 1'b1; r_addr[3] = 27'h0300; r_write[3] = 1'b1;
    repeat (6) step();
    check_eq("t5_first_grant", 128'(grants.size() > 0 ? grants[0] : -1), 128'(0));
    check_eq("t5_no_abandoned_rsp", 128'(dut_done[3] - base), 128'(0));

    // Controller response asserted during ISSUE is ignored.
    do_reset();
    r_valid[1] = 1'b1; r_addr[1] = 27'h0111; r_write[1] = 1'b0;
    base = dut_done[1];
    step();
    ack_pct = 0;
    repeat (3) begin drive(); data_rsp_ready_i = 1'b1; cycle(); end
    ack_pct = 100;
    drive(); data_rsp_ready_i = 1'b1; cycle();
    check_eq("t6_no_early_rsp", 128'(dut_done[1] - base), 128'(0));
    rsp_cfg = 2;
    repeat (8) step();
    check_eq("t6_done", 128'(dut_done[1] - base), 128'(1));

    // Random traffic.
    do_reset();
    refill_pct = 60; spawn_pct = 20; ack_pct = 70; stale_pct = 10;
    reset_pmil = 3; rsp_cfg = -2;
    repeat (1500) step();
    quiet_knobs();
    r_valid = '0;
    repeat (30) step();
    for (int p = 0; p < NP; p++) check_eq("served", 128'(dut_done[p]), 128'(m_done[p]));

    errs = n_bad;
    $display("test done: total=%0d bad=%0d", n_checks, errs);
    $finish;
  end

endmodule

// File: doc/sddr_port_arbiter.md
# sddr_port_arbiter

Round-robin arbiter that shares the single data command port of `sddr_ctrl` among `NUM_PORTS` requesters (CPU cache, DMA, video fetch, ...). It accepts one request at a time, forwards it on the controller's valid/ack interface, and waits for the controller's response pulse. It then routes the response back to the granted port. It sits in the CPU clock domain between the system interconnect and `sddr_ctrl`, and keeps at most one transaction outstanding.

## Interface
Parameters:
- `NUM_PORTS`, 4, number of requesters (2..8)
- `ADDR_BITS`, 27, byte address width (BANK 3 + ROW 13 + COL 10 + 1)
- `DATA_WIDTH`, 128, burst payload width (BURST_LENGTH 8 × DATA_BITS 16)
- `TIMEOUT_CYCLES`, 1024, response watchdog limit; 0 disables the watchdog

Ports:
- `cpu_clock_i` in 1: single clock. All logic is on the rising edge.
- `reset_i` in 1: synchronous, active-high reset.
- `req_valid_i` in [NUM_PORTS]: request pending, per port.
- `req_address_i` in [NUM_PORTS][ADDR_BITS]: request address, per port.
- `req_write_i` in [NUM_PORTS]: 1 = write, per port.
- `req_data_i` in [NUM_PORTS][DATA_WIDTH]: write payload, per port.
- `req_ack_o` out [NUM_PORTS]: one-cycle pulse when the port's request is accepted.
- `rsp_ready_o` out [NUM_PORTS]: one-cycle pulse when the port's transaction completes.
- `rsp_data_o` out DATA_WIDTH: read data, shared by all ports. Valid during `rsp_ready_o` and held until the next response.
- `rsp_error_o` out 1: qualifies `rsp_ready_o`; 1 = watchdog timeout.
- `data_cmd_valid_o`, `data_cmd_address_o`, `data_cmd_write_o`, `data_cmd_data_o` out: connect to the controller's command inputs.
- `data_cmd_ack_i` in 1: controller ready. A transfer occurs when both valid and ack are high.
- `data_rsp_ready_i` in 1: controller completion pulse.
- `data_data_i` in DATA_WIDTH: controller read data.
- `busy_o` out 1: state ≠ IDLE.
- `owner_o` out $clog2(NUM_PORTS): index of the current or last granted port.

## Operation
The arbiter has three states: IDLE, ISSUE and WAIT_RSP.

IDLE:
- If any `req_valid_i` is high, pick the first valid port searching upward from `last_grant+1`, wrapping modulo NUM_PORTS.
- Pulse `req_ack_o[p]` combinationally in this same cycle.
- Latch the port's address, write flag and data into the command registers, and set `owner` = p.
- Go to ISSUE.

ISSUE:
- `data_cmd_valid_o` = 1 and the command registers are stable.
- When `data_cmd_ack_i` = 1: go to WAIT_RSP, clear the watchdog, set `last_grant` = owner.

WAIT_RSP:
- When `data_rsp_ready_i` = 1: capture `data_data_i` into `rsp_data_o`, pulse `rsp_ready_o[owner]` with `rsp_error_o` = 0, and go to IDLE.
- Write transactions also complete this way; `rsp_data_o` is don't-care for writes.
- Watchdog: the counter increments each cycle in WAIT_RSP. When TIMEOUT_CYCLES ≠ 0 and the count reaches TIMEOUT_CYCLES−1 without a response, pulse `rsp_ready_o[owner]` with `rsp_error_o` = 1, leave `rsp_data_o` unchanged, and go to IDLE.

Ignored events:
- `data_rsp_ready_i` in IDLE or ISSUE (stale response) is ignored.
- `req_valid_i` of non-granted ports is ignored while busy. Those requests stay pending and are not dropped.

Requester rules:
- A requester holds `req_valid_i` and its payload stable until it sees `req_ack_o`.
- After ack, the requester is free. It may present a new request immediately; that request is arbitrated on the next return to IDLE.

Fairness: a port that was just served is not re-granted before every other valid port has been served once.

Reset behaviour:
- All outputs are 0; `rsp_data_o` = 0; `owner_o` = 0.
- `last_grant` = NUM_PORTS−1, so port 0 has first priority.
- State = IDLE and the watchdog = 0.
- A reset during ISSUE or WAIT_RSP abandons the transaction with no `rsp_ready_o` pulse. A later controller response is treated as stale.

## Timing
- Grant to `data_cmd_valid_o`: 1 cycle (registered).
- If `data_cmd_ack_i` is already high, acceptance happens in the first ISSUE cycle.
- `data_rsp_ready_i` to `rsp_ready_o`: 1 cycle (registered pulse, with data registered alongside).
- Minimum turnaround back to IDLE: 1 cycle after the response. The next grant occurs in that IDLE cycle.
- Width rules:
  - The watchdog counter is 32 bits and saturates; it never wraps.
  - `owner_o` is $clog2(NUM_PORTS) bits. NUM_PORTS is not required to be a power of two; the wrap is explicit modulo.

## Structure
- Package `sddr_pkg`:
  - `arb_state_t` enum {ARB_IDLE, ARB_ISSUE, ARB_WAIT_RSP}
  - localparams SDDR_ADDR_BITS = 27 and SDDR_BURST_BITS = 128, shared with `sddr_ctrl` instantiation sites.
- Sub-module `sddr_rr_picker`: combinational round-robin one-hot picker.
  - Inputs: request vector, last-grant index.
  - Outputs: one-hot grant, index, any-valid.
  - Implemented with a double-width mask-and-priority scheme.
  - Reused by future refresh and priority schedulers.

## Test plan
- Reset, then `req_valid_i` = 4'b0001, addr 0x1000, read. Expected: `req_ack_o[0]` pulses; the next cycle `data_cmd_valid_o` = 1, addr 0x1000, write = 0. Respond `data_data_i` = 128'hA5.., then `rsp_ready_o[0]` pulses with `rsp_data_o` = 128'hA5...
- All four ports valid continuously. Expected grant order is 0,1,2,3,0; each port gets exactly one `rsp_ready_o` per round.
- Port 2 write with `data_cmd_ack_i` held low for 5 cycles. Expected: `data_cmd_valid_o` stays high, command fields are stable, and the transfer occurs on the 6th cycle.
- TIMEOUT_CYCLES = 16 with no response. Expected: after 16 WAIT_RSP cycles, `rsp_ready_o[owner]` = 1 and `rsp_error_o` = 1; the next request is then granted. A late `data_rsp_ready_i` arriving in IDLE produces no pulse.
- `reset_i` asserted in WAIT_RSP. Expected: all outputs return to 0 the next cycle, there is no response pulse, and port 0 wins the next contention with port 3.
- `data_rsp_ready_i` asserted during ISSUE. Expected: ignored; the transaction completes only on a response in WAIT_RSP.
